shift_sequencer: RTL and testbench

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

---
 rtl/shift_sequencer_if.sv | 38 +++
 rtl/shift_sequencer.sv | 254 +++++++++++++++++++++++++
 tb/tb_shift_sequencer.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_sequencer_if.sv
// shift_sequencer_if
//   Groups the control inputs and shift-register outputs of shift_sequencer.
//   Ports (signals):
//     start   - request to begin a sequence (honoured only in IDLE)
//     stop    - abort request, forces DONE from LOAD/LEFT/RIGHT
//     pause   - freezes shifting while high
//     pattern - 8-bit parallel value to load
//     steps   - shifts per direction (0..15)
//     reps    - left/right round trips, 0 means 8
//     S1, S0  - shift-register mode: 00 hold, 01 right, 10 left, 11 load
//     D       - parallel data for the shift register
//     busy    - high in every state except IDLE
//     done    - one-cycle completion pulse
//   modport master : the side that drives the requests (testbench / host)
//   modport slave  : the sequencer itself
interface shift_sequencer_if;
  logic       start;
  logic       stop;
  logic       pause;
  logic [7:0] pattern;
  logic [3:0] steps;
  logic [2:0] reps;
  logic       S1;
  logic       S0;
  logic [7:0] D;
  logic       busy;
  logic       done;

  modport master (
    output start, stop, pause, pattern, steps, reps,
    input  S1, S0, D, busy, done
  );

  modport slave (
    input  start, stop, pause, pattern, steps, reps,
    output S1, S0, D, busy, done
  );
endinterface

// File: rtl/shift_sequencer.sv
// shift_sequencer
//   Drives the mode pins and parallel data of an external universal shift
//   register: one parallel load of a captured pattern, then R round trips of
//   `steps` left shifts followed by `steps` right shifts, then a done pulse.
//   Ports:
//     CP  - system clock, all state changes on the rising edge
//     CR  - asynchronous active-high reset
//     bus - shift_sequencer_if.slave (start/stop/pause/pattern/steps/reps in,
//           S1/S0/D/busy/done out)
//   All outputs come straight from flops; they are loaded with the decode of
//   the next state so that they always describe the current registered state.
module shift_sequencer (
  input  logic             CP,
  input  logic             CR,
  shift_sequencer_if.slave bus
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_LEFT  = 3'd2;
  localparam logic [2:0] ST_RIGHT = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  // Registered state and captured operands
  logic [2:0] state_r;
  logic       hold_r;       // current LEFT/RIGHT cycle is a paused (00) cycle
  logic [7:0] pat_r;
  logic [3:0] steps_r;
  logic [2:0] reps_r;
  logic [3:0] step_cnt_r;   // shifts completed in the current direction
  logic [3:0] trip_cnt_r;   // round trips completed

  // Registered outputs
  logic [1:0] mode_r;
  logic [7:0] d_r;
  logic       busy_r;
  logic       done_r;

  // Next-state values
  logic [2:0] state_nx_s;
  logic       hold_nx_s;
  logic [7:0] pat_nx_s;
  logic [3:0] steps_nx_s;
  logic [2:0] reps_nx_s;
  logic [3:0] step_cnt_nx_s;
  logic [3:0] trip_cnt_nx_s;
  logic [1:0] mode_nx_s;
  logic [7:0] d_nx_s;
  logic       busy_nx_s;
  logic       done_nx_s;

  // Counter helpers
  logic [3:0] step_inc_s;
  logic [3:0] trip_inc_s;
  logic       step_last_s;
  logic       trip_last_s;

  // Effective round-trip count: a reps field of zero encodes eight trips.
  function automatic logic [3:0] trip_target(input logic [2:0] r);
    if (r == 3'd0) begin
      return 4'd8;
    end else begin
      return {1'b0, r};
    end
  endfunction

  assign step_inc_s  = step_cnt_r + 4'd1;
  assign trip_inc_s  = trip_cnt_r + 4'd1;
  // The shift happening this cycle is the last one of the current direction.
  assign step_last_s = (step_inc_s == steps_r);
  // The round trip finishing this cycle is the last one.
  assign trip_last_s = (trip_inc_s == trip_target(reps_r));

  // Next-state, counter and capture logic
  always_comb begin
    state_nx_s    = state_r;
    hold_nx_s     = 1'b0;
    pat_nx_s      = pat_r;
    steps_nx_s    = steps_r;
    reps_nx_s     = reps_r;
    step_cnt_nx_s = step_cnt_r;
    trip_cnt_nx_s = trip_cnt_r;

    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_nx_s    = ST_LOAD;
          pat_nx_s      = bus.pattern;
          steps_nx_s    = bus.steps;
          reps_nx_s     = bus.reps;
          step_cnt_nx_s = 4'd0;
          trip_cnt_nx_s = 4'd0;
        end else begin
          state_nx_s    = ST_IDLE;
        end
      end

      ST_LOAD: begin
        if (bus.stop) begin
          state_nx_s = ST_DONE;
        end else if (steps_r != 4'd0) begin
          state_nx_s    = ST_LEFT;
          step_cnt_nx_s = 4'd0;
          hold_nx_s     = bus.pause;
        end else begin
          state_nx_s = ST_DONE;
        end
      end

      ST_LEFT: begin
        // stop outranks pause and expiry; a paused cycle shifts nothing,
        // so the counter only advances on a cycle that drove 10.
        if (bus.stop) begin
          state_nx_s = ST_DONE;
        end else if (hold_r) begin
          hold_nx_s  = bus.pause;
        end else if (step_last_s) begin
          state_nx_s    = ST_RIGHT;
          step_cnt_nx_s = 4'd0;
          hold_nx_s     = bus.pause;
        end else begin
          step_cnt_nx_s = step_inc_s;
          hold_nx_s     = bus.pause;
        end
      end

      ST_RIGHT: begin
        if (bus.stop) begin
          state_nx_s = ST_DONE;
        end else if (hold_r) begin
          hold_nx_s  = bus.pause;
        end else if (step_last_s) begin
          step_cnt_nx_s = 4'd0;
          trip_cnt_nx_s = trip_inc_s;
          if (trip_last_s) begin
            state_nx_s = ST_DONE;
          end else begin
            state_nx_s = ST_LEFT;
            hold_nx_s  = bus.pause;
          end
        end else begin
          step_cnt_nx_s = step_inc_s;
          hold_nx_s     = bus.pause;
        end
      end

      ST_DONE: begin
        state_nx_s    = ST_IDLE;
        step_cnt_nx_s = 4'd0;
        trip_cnt_nx_s = 4'd0;
      end

      default: begin
        state_nx_s    = ST_IDLE;
        step_cnt_nx_s = 4'd0;
        trip_cnt_nx_s = 4'd0;
      end
    endcase
  end

  // Moore output decode of the next state, loaded into the output flops
  always_comb begin
    mode_nx_s = MODE_HOLD;
    d_nx_s    = 8'h00;
    busy_nx_s = 1'b0;
    done_nx_s = 1'b0;

    case (state_nx_s)
      ST_IDLE: begin
        mode_nx_s = MODE_HOLD;
        d_nx_s    = 8'h00;
      end

      ST_LOAD: begin
        mode_nx_s = MODE_LOAD;
        d_nx_s    = pat_nx_s;
        busy_nx_s = 1'b1;
      end

      ST_LEFT: begin
        if (hold_nx_s) begin
          mode_nx_s = MODE_HOLD;
        end else begin
          mode_nx_s = MODE_LEFT;
        end
        d_nx_s    = pat_nx_s;
        busy_nx_s = 1'b1;
      end

      ST_RIGHT: begin
        if (hold_nx_s) begin
          mode_nx_s = MODE_HOLD;
        end else begin
          mode_nx_s = MODE_RIGHT;
        end
        d_nx_s    = pat_nx_s;
        busy_nx_s = 1'b1;
      end

      ST_DONE: begin
        mode_nx_s = MODE_HOLD;
        d_nx_s    = pat_nx_s;
        busy_nx_s = 1'b1;
        done_nx_s = 1'b1;
      end

      default: begin
        mode_nx_s = MODE_HOLD;
        d_nx_s    = 8'h00;
      end
    endcase
  end

  // State, captured operands, counters and output flops
  always_ff @(posedge CP or posedge CR) begin
    if (CR) begin
      state_r    <= ST_IDLE;
      hold_r     <= 1'b0;
      pat_r      <= 8'h00;
      steps_r    <= 4'd0;
      reps_r     <= 3'd0;
      step_cnt_r <= 4'd0;
      trip_cnt_r <= 4'd0;
      mode_r     <= MODE_HOLD;
      d_r        <= 8'h00;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      hold_r     <= hold_nx_s;
      pat_r      <= pat_nx_s;
      steps_r    <= steps_nx_s;
      reps_r     <= reps_nx_s;
      step_cnt_r <= step_cnt_nx_s;
      trip_cnt_r <= trip_cnt_nx_s;
      mode_r     <= mode_nx_s;
      d_r        <= d_nx_s;
      busy_r     <= busy_nx_s;
      done_r     <= done_nx_s;
    end
  end

  assign bus.S1   = mode_r[1];
  assign bus.S0   = mode_r[0];
  assign bus.D    = d_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;

endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer
//   Randomised and directed stimulus for shift_sequencer. A queue-based
//   model expands each accepted start into the list of per-cycle actions
//   (LOAD, steps x LEFT, steps x RIGHT per trip, DONE); pause inserts hold
//   cycles in front of a pending shift and stop discards the rest of the
//   list. A compare process checks every output on every falling edge.
module tb_shift_sequencer;

  logic CP = 1'b0;
  logic CR = 1'b1;

  shift_sequencer_if bus ();

  shift_sequencer dut (
    .CP  (CP),
    .CR  (CR),
    .bus (bus)
  );

  always #5 CP = ~CP;

  int n_checks = 0;
  int n_errors = 0;

  localparam int C_IDLE  = 0;
  localparam int C_LOAD  = 1;
  localparam int C_LEFT  = 2;
  localparam int C_RIGHT = 3;
  localparam int C_DONE  = 4;
  localparam int C_HOLD  = 5;

  int         m_cur = C_IDLE;
  int         m_q[$];
  logic [7:0] m_pat = 8'h00;

  // attached rotating shift register driven by the sequencer's outputs
  logic [7:0] sr = 8'h00;

  // per-run statistics gathered from the DUT
  int         cnt_busy, cnt_done, cnt_left, cnt_right, cnt_hold;
  logic [1:0] first_mode;
  logic [7:0] first_d;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [1:0] exp_mode(input int c);
    case (c)
      C_LOAD:  return 2'b11;
      C_LEFT:  return 2'b10;
      C_RIGHT: return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  task automatic model_step();
    if (m_cur == C_IDLE) begin
      if (bus.start) begin
        int r;
        r = (bus.reps == 3'd0) ? 8 : int'(bus.reps);
        m_pat = bus.pattern;
        m_q.delete();
        if (bus.steps != 4'd0) begin
          for (int t = 0; t < r; t++) begin
            for (int s = 0; s < int'(bus.steps); s++) m_q.push_back(C_LEFT);
            for (int s = 0; s < int'(bus.steps); s++) m_q.push_back(C_RIGHT);
          end
        end
        m_q.push_back(C_DONE);
        m_cur = C_LOAD;
      end
    end else if (m_cur == C_DONE) begin
      m_cur = C_IDLE;
      m_pat = 8'h00;
    end else if (bus.stop) begin
      m_q.delete();
      m_cur = C_DONE;
    end else if (bus.pause && (m_q[0] == C_LEFT || m_q[0] == C_RIGHT)) begin
      m_cur = C_HOLD;
    end else begin
      m_cur = m_q.pop_front();
    end
  endtask

  // reference model advance
  initial begin
    forever begin
      @(posedge CP or posedge CR);
      if (CR) begin
        m_cur = C_IDLE;
        m_pat = 8'h00;
        m_q.delete();
      end else begin
        model_step();
      end
    end
  end

  // compare process: every output, every cycle
  initial begin
    forever begin
      @(negedge CP);
      chk("mode", {6'd0, bus.S1, bus.S0}, {6'd0, exp_mode(m_cur)});
      chk("D", bus.D, (m_cur == C_IDLE) ? 8'h00 : m_pat);
      chk("busy", {7'd0, bus.busy}, {7'd0, (m_cur != C_IDLE)});
      chk("done", {7'd0, bus.done}, {7'd0, (m_cur == C_DONE)});
    end
  end

  // rotating register: left rotate on 10, right rotate on 01
  always @(posedge CP) begin
    case ({bus.S1, bus.S0})
      2'b11:   sr <= bus.D;
      2'b10:   sr <= {sr[6:0], sr[7]};
      2'b01:   sr <= {sr[0], sr[7:1]};
      default: sr <= sr;
    endcase
  end

  // One sequence: start is sampled at edge 0; later inputs are indexed by
  // the edge number that samples them.
  task automatic run_seq(input logic [7:0] pat, input logic [3:0] st, input logic [2:0] rp,
                         input int p_from, input int p_len, input int stop_at,
                         input int again_at, input int cr_at, input bit rnd);
    int k;
    bit fin;
    cnt_busy = 0; cnt_done = 0; cnt_left = 0; cnt_right = 0; cnt_hold = 0;
    first_mode = 2'b00; first_d = 8'h00;
    @(negedge CP);
    bus.start = 1'b1; bus.pattern = pat; bus.steps = st; bus.reps = rp;
    bus.stop = 1'b0; bus.pause = 1'b0;
    k = 0; fin = 1'b0;
    while (!fin) begin
      @(posedge CP);
      if (k == cr_at) begin
        #2;
        CR = 1'b1;
        #1;
        chk("cr_mode", {6'd0, bus.S1, bus.S0}, 8'h00);
        chk("cr_D", bus.D, 8'h00);
        chk("cr_busy", {7'd0, bus.busy}, 8'h00);
        chk("cr_done", {7'd0, bus.done}, 8'h00);
        #1;
        CR = 1'b0;
      end
      @(negedge CP);
      if (bus.busy) cnt_busy++;
      if (bus.done) cnt_done++;
      if ({bus.S1, bus.S0} == 2'b10) cnt_left++;
      if ({bus.S1, bus.S0} == 2'b01) cnt_right++;
      if ({bus.S1, bus.S0} == 2'b00 && bus.busy && !bus.done) cnt_hold++;
      if (k == 0) begin
        first_mode = {bus.S1, bus.S0};
        first_d    = bus.D;
      end
      bus.start = (k + 1 == again_at);
      if (rnd) begin
        bus.pattern = 8'($urandom_range(0, 255));
        bus.steps   = 4'($urandom_range(0, 15));
        bus.reps    = 3'($urandom_range(0, 7));
      end else begin
        bus.pattern = ~pat;
        bus.steps   = st + 4'd1;
        bus.reps    = rp + 3'd1;
      end
      bus.pause = ((k + 1 >= p_from) && (k + 1 < p_from + p_len)) ||
                  (rnd && ($urandom_range(0, 7) == 0));
      bus.stop  = (k + 1 == stop_at);
      if (!bus.busy) begin
        fin = 1'b1;
      end else if (k > 3000) begin
        n_checks++;
        n_errors++;
        $display("FAIL timeout: sequence still busy after %0d cycles, required idle", k);
        fin = 1'b1;
      end
      k++;
    end
    bus.start = 1'b0; bus.stop = 1'b0; bus.pause = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0; bus.stop = 1'b0; bus.pause = 1'b0;
    bus.pattern = 8'h00; bus.steps = 4'd0; bus.reps = 3'd0;
    repeat (3) @(negedge CP);
    chk("rst_mode", {6'd0, bus.S1, bus.S0}, 8'h00);
    chk("rst_D", bus.D, 8'h00);
    chk("rst_busy", {7'd0, bus.busy}, 8'h00);
    chk("rst_done", {7'd0, bus.done}, 8'h00);
    CR = 1'b0;
    repeat (2) @(negedge CP);

    // 80, 8 steps, 1 trip: register comes back to 80
    run_seq(8'h80, 4'd8, 3'd1, -10, 0, -1, -1, -1, 1'b0);
    chk("basic_first_mode", {6'd0, first_mode}, 8'h03);
    chk("basic_first_D", first_d, 8'h80);
    chk("basic_left", 8'(cnt_left), 8'd8);
    chk("basic_right", 8'(cnt_right), 8'd8);
    chk("basic_busy", 8'(cnt_busy), 8'd18);
    chk("basic_done", 8'(cnt_done), 8'd1);
    chk("basic_sr", sr, 8'h80);

    // 3 steps, reps 0 -> 8 trips, 50 busy cycles
    run_seq(8'hC3, 4'd3, 3'd0, -10, 0, -1, -1, -1, 1'b0);
    chk("r8_busy", 8'(cnt_busy), 8'd50);
    chk("r8_left", 8'(cnt_left), 8'd24);
    chk("r8_right", 8'(cnt_right), 8'd24);
    chk("r8_done", 8'(cnt_done), 8'd1);

    // steps 0 -> LOAD then DONE
    run_seq(8'h5A, 4'd0, 3'd3, -10, 0, -1, -1, -1, 1'b0);
    chk("s0_busy", 8'(cnt_busy), 8'd2);
    chk("s0_first_mode", {6'd0, first_mode}, 8'h03);
    chk("s0_first_D", first_d, 8'h5A);
    chk("s0_done", 8'(cnt_done), 8'd1);

    // pause sampled at edges 3..6 after two left shifts
    run_seq(8'h81, 4'd8, 3'd1, 3, 4, -1, -1, -1, 1'b0);
    chk("pause_hold", 8'(cnt_hold), 8'd4);
    chk("pause_left", 8'(cnt_left), 8'd8);
    chk("pause_right", 8'(cnt_right), 8'd8);
    chk("pause_busy", 8'(cnt_busy), 8'd22);

    // stop during RIGHT, with a start pulse while busy
    run_seq(8'h3C, 4'd8, 3'd2, -10, 0, 12, 5, -1, 1'b0);
    chk("stop_busy", 8'(cnt_busy), 8'd13);
    chk("stop_left", 8'(cnt_left), 8'd8);
    chk("stop_right", 8'(cnt_right), 8'd3);
    chk("stop_done", 8'(cnt_done), 8'd1);

    // reset pulse mid-LEFT, then a fresh full sequence
    run_seq(8'hE7, 4'd8, 3'd1, -10, 0, -1, -1, 3, 1'b0);
    chk("cr_no_done", 8'(cnt_done), 8'd0);
    run_seq(8'h3C, 4'd2, 3'd1, -10, 0, -1, -1, -1, 1'b0);
    chk("after_cr_busy", 8'(cnt_busy), 8'd6);
    chk("after_cr_done", 8'(cnt_done), 8'd1);
    chk("after_cr_sr", sr, 8'h3C);

    // randomised sequences against the model
    for (int i = 0; i < 30; i++) begin
      int sa;
      int aa;
      sa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 60)) : -1;
      aa = int'($urandom_range(1, 20));
      run_seq(8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)),
              3'($urandom_range(0, 7)), -10, 0, sa, aa, -1, 1'b1);
    end

    repeat (3) @(negedge CP);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
